// File: rtl/onchip_memory_stream_loader_pkg.sv
// Shared types and helpers for the stream loader: FSM states, default geometry, lane masks.
// Pure declarations; no latency or backpressure of its own.
package onchip_memory_stream_loader_pkg;

  localparam int DEPTH_DEF  = 5120;
  localparam int ADDR_W_DEF = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    OVF  = 2'd2
  } state_t;

  // Lanes 0..k enabled.
  function automatic logic [3:0] lane_mask(input logic [1:0] k);
    logic [3:0] m;
    case (k)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = {8{be[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/onchip_memory_stream_loader_if.sv
// Byte-stream sink plus on-chip memory write port; master = the loader, slave = its environment.
// Wires only; no latency; the stream side is never backpressured.
interface onchip_memory_stream_loader_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        st_data;
  logic              st_valid;
  logic              st_sop;
  logic              st_eop;
  logic              st_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;

  modport master (
    input  st_data, st_valid, st_sop, st_eop,
    output st_ready,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );

  modport slave (
    output st_data, st_valid, st_sop, st_eop,
    input  st_ready,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_memory_stream_loader_byte_packer.sv
// Little-endian byte-to-word assembler; the completed word is presented combinationally with its byte.
// Accepts one byte per cycle with no stall; SOP discards any partial word and restarts at lane 0.
module onchip_memory_stream_loader_byte_packer
  import onchip_memory_stream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_vld,
  input  logic [7:0]  in_dat,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        word_complete,
  output logic [31:0] word_dat,
  output logic [3:0]  word_be
);

  logic [31:0] word_q;
  logic [3:0]  mask_q;
  logic [1:0]  lane_q;

  logic [1:0]  lane_c;
  logic [31:0] word_base;
  logic [3:0]  mask_base;

  always_comb begin
    lane_c        = in_sop ? 2'd0  : lane_q;
    word_base     = in_sop ? '0    : word_q;
    mask_base     = in_sop ? '0    : mask_q;
    word_dat      = word_base | ({24'd0, in_dat} << {lane_c, 3'b000});
    word_be       = mask_base | lane_mask(lane_c);
    word_complete = in_vld & ((lane_c == 2'd3) | in_eop);
  end

  // Clearing on completion lets the very next byte open a fresh word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      mask_q <= '0;
      lane_q <= '0;
    end else if (in_vld) begin
      if (word_complete) begin
        word_q <= '0;
        mask_q <= '0;
        lane_q <= '0;
      end else begin
        word_q <= word_dat;
        mask_q <= word_be;
        lane_q <= lane_c + 2'd1;
      end
    end
  end

endmodule

// File: rtl/onchip_memory_stream_loader.sv
// Packs an Avalon-ST byte packet into 32-bit words written to consecutive on-chip memory words.
// Write appears 1 cycle after the completing byte, done 1 cycle later; st_ready is always 1.
module onchip_memory_stream_loader
  import onchip_memory_stream_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      base_addr,
  onchip_memory_stream_loader_if.master bus,
  output logic                   done,
  output logic [ADDR_W:0]        word_count,
  output logic [31:0]            checksum,
  output logic                   err_overflow,
  output logic                   err_truncated
);

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] WC_MAX  = '1;
  localparam logic [ADDR_W:0] ONE_P   = (ADDR_W+1)'(1);

  state_t          state;
  logic [ADDR_W:0] ptr;
  logic            done_pend;

  logic            restart;
  logic            in_pkt;
  logic            pack_en;
  logic            end_pkt;
  logic [ADDR_W:0] eff_ptr;
  logic [ADDR_W:0] eff_wc;
  logic [31:0]     eff_cs;
  logic            in_range;
  logic            do_write;
  logic            do_ovf;

  logic            pk_complete;
  logic [31:0]     pk_word;
  logic [3:0]      pk_be;

  assign bus.st_ready  = 1'b1;
  assign bus.mem_clken = 1'b1;

  // eff_* is the packet context the current byte belongs to: a SOP byte sees a fresh one.
  always_comb begin
    restart  = bus.st_valid & bus.st_sop;
    in_pkt   = restart | (state != IDLE);
    pack_en  = bus.st_valid & (bus.st_sop | (state == PACK));
    end_pkt  = bus.st_valid & bus.st_eop & in_pkt;
    eff_ptr  = restart ? {1'b0, base_addr} : ptr;
    eff_wc   = restart ? '0 : word_count;
    eff_cs   = restart ? '0 : checksum;
    in_range = eff_ptr < DEPTH_P;
    do_write = pk_complete & in_range;
    do_ovf   = pk_complete & ~in_range;
  end

  onchip_memory_stream_loader_byte_packer u_packer (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_vld        (pack_en),
    .in_dat        (bus.st_data),
    .in_sop        (bus.st_sop),
    .in_eop        (bus.st_eop),
    .word_complete (pk_complete),
    .word_dat      (pk_word),
    .word_be       (pk_be)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      ptr                <= '0;
      word_count         <= '0;
      checksum           <= '0;
      err_overflow       <= 1'b0;
      err_truncated      <= 1'b0;
      done_pend          <= 1'b0;
      done               <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_writedata  <= '0;
      bus.mem_byteenable <= '0;
    end else begin
      bus.mem_write      <= do_write;
      bus.mem_chipselect <= do_write;
      if (do_write) begin
        bus.mem_address    <= eff_ptr[ADDR_W-1:0];
        bus.mem_writedata  <= pk_word;
        bus.mem_byteenable <= pk_be;
      end

      done_pend <= end_pkt;
      done      <= done_pend;

      // ptr stops at DEPTH: the first out-of-range word moves to OVF instead of wrapping.
      ptr        <= do_write ? eff_ptr + ONE_P : eff_ptr;
      word_count <= (do_write && (eff_wc != WC_MAX)) ? eff_wc + ONE_P : eff_wc;
      checksum   <= do_write ? eff_cs + (pk_word & lane_bits(pk_be)) : eff_cs;

      err_overflow  <= (err_overflow & ~restart) | do_ovf;
      err_truncated <= restart ? (state == PACK) : err_truncated;

      if (end_pkt) begin
        state <= IDLE;
      end else if (do_ovf) begin
        state <= OVF;
      end else if (restart) begin
        state <= PACK;
      end
    end
  end

endmodule

// File: doc/onchip_memory_stream_loader.md
Name: onchip_memory_stream_loader

Overview:
- Avalon-ST byte sink → Avalon-MM write master. Sits directly upstream of the on-chip memory s1/s2 slave (13-bit word address, 32-bit data, 4-bit byteenable, single-cycle write, no waitrequest).
- Packs an incoming byte packet little-endian into 32-bit words and writes them to consecutive word addresses starting at base_addr.
- Used for boot-image/table loading from a UART or JTAG byte stream.
- Reports completion, word count, a running checksum and error flags.

Parameters:
- DEPTH, 5120, memory depth in words; valid addresses are 0..DEPTH-1.
- ADDR_W, 13, word-address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- base_addr  in  ADDR_W  start word address; sampled on the SOP byte.
- st_data  in  8  stream byte.
- st_valid  in  1  byte valid.
- st_sop  in  1  first byte of packet.
- st_eop  in  1  last byte of packet.
- st_ready  out  1  byte accepted when st_valid & st_ready.
- mem_address  out  ADDR_W  write word address.
- mem_byteenable  out  4  lane enables; bit i = bits 8i+7:8i.
- mem_chipselect  out  1  asserted together with mem_write.
- mem_write  out  1  one-cycle write strobe.
- mem_writedata  out  32  packed word.
- mem_clken  out  1  memory clock enable; tied to 1.
- done  out  1  one-cycle pulse at packet end.
- word_count  out  ADDR_W+1  words written in the current or last packet.
- checksum  out  32  wrapping sum of written words, with disabled lanes counted as 0.
- err_overflow  out  1  sticky; cleared on the next SOP.
- err_truncated  out  1  sticky; cleared on the next SOP.

Behaviour:
- Reset values: all outputs 0 except mem_clken=1 and st_ready=1. FSM enters IDLE, lane=0, assembly register=0.
- st_ready is 1 in all states. The block never backpressures, because the memory accepts one write per cycle.
- Datapath: assembly register (word, lane 0..3, byte-enable mask) followed by a registered write stage. All mem_* outputs are registered.

FSM states: IDLE, PACK, OVF.
- IDLE:
  - Bytes without SOP are dropped silently.
  - SOP byte: ptr←base_addr, word_count←0, checksum←0, errors cleared; byte goes to lane 0; go to PACK.
  - SOP+EOP on the same byte: a single-byte packet.
- PACK, on each accepted byte:
  - Byte goes to lane `lane`, mask bit set, lane++.
  - If lane==3 or EOP: the word is complete.
- Completion timing:
  - Word completed by the byte accepted in cycle t → mem_write=mem_chipselect=1 in cycle t+1, with mem_address=ptr, writedata=word, byteenable=mask.
  - Same cycle t+1: ptr++, word_count++, checksum += masked word.
  - Assembly register is cleared in cycle t, so a byte in cycle t+1 starts a fresh word. Sustained 1 byte/cycle is supported.
- Tail: EOP on lane k<3 → byteenable has bits 0..k set, and unused data lanes are 0.
- EOP → done pulses in cycle t+2 (the cycle after the final write); go to IDLE.
- SOP while in PACK (missing EOP):
  - Discard the partial word (no write) and set err_truncated.
  - Restart the packet as in IDLE, except that err_truncated stays set for this packet.
- Overflow: a word is complete while ptr == DEPTH-1 and it is written, but further bytes follow.
  - Next completed word with ptr ≥ DEPTH → no write, set err_overflow, go to OVF.
  - No address wrap-around.
- OVF: bytes are consumed and dropped.
  - On EOP: done pulses at t+2, go to IDLE.
  - On SOP: restart as in IDLE, which clears the errors.
- base_addr > DEPTH-1 at SOP: the first completed word triggers overflow.
- Reset mid-packet: immediate return to reset values. No write is issued, including any write pending in the staging stage.
- Arithmetic widths:
  - ptr is ADDR_W+1 bits internally, to detect ≥ DEPTH.
  - word_count saturates at 2^(ADDR_W+1)-1.
  - checksum is modulo 2^32.

Decomposition:
- Shared package loader_pkg: FSM state enum (IDLE/PACK/OVF), DEPTH/ADDR_W defaults, and a lane-mask function (lanes 0..k → 4-bit mask).
- One natural sub-module, byte_packer: lane counter, assembly register and mask, with a "word_complete" output.
- FSM, address pointer, write stage, checksum and error logic live in the top level.

Test Plan:
- base_addr=0x010; 8 bytes 0x01..0x08 back-to-back with SOP/EOP → writes @0x010 data=0x04030201 be=0xF, then @0x011 data=0x08070605 be=0xF, each 1 cycle after its 4th byte. done 1 cycle after the last write; word_count=2; checksum=0x0C0A0806.
- 6-byte packet 0xAA..0xAF with gaps between bytes → second write has data=0x0000AFAE, be=0x3; word_count=2.
- Single byte 0x5A with SOP+EOP, base_addr=0 → one write @0 data=0x0000005A be=0x1; done pulse.
- base_addr=DEPTH-1, 8-byte packet → one write @5119, no second write, err_overflow=1; done on EOP; next SOP clears err_overflow.
- SOP, 2 bytes, then a new SOP with 4 bytes + EOP → no write for the first partial word; one full word written at the new base_addr; err_truncated=1.
- reset_n low for 1 cycle in the cycle after a word completes → no mem_write; all outputs at reset values. The next packet writes correctly.
